// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction store and its loader.
package imem_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int INSTR_W    = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler; word_valid_o marks the byte that completes a word.
module byte_packer
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (clear_i) begin
            cnt_q <= 2'd0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            // newest byte enters at the top, so the first byte ends up in [7:0]
            sh_q  <= {byte_i, sh_q[23:8]};
        end
    end

    assign word_o       = {byte_i, sh_q};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction store; holds the core in reset while loading.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data.
//
// state  | meaning
// IDLE   | waiting for start
// LEN_LO | take word count bits [7:0]
// LEN_HI | take word count bits [15:8], range-check it
// DATA   | pack bytes into words, write each completed word
// CSUM   | compare trailing byte with running sum (checksum build only)
// DONE   | load succeeded, core released
// ERR    | load failed, core released
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    loader_state_t      state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [7:0]         last_q, last_d;
    logic [7:0]         word_idx_q, word_idx_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0] wr_data_q, wr_data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               accept;
    logic               pack_clear;
    logic               pack_valid;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic [15:0]        n_full;

    assign in_ready   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CSUM);
    assign accept     = in_valid && in_ready;
    assign pack_valid = accept && (state_q == DATA);
    assign n_full     = {in_data, len_lo_q};

    byte_packer u_packer (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        last_d     = last_q;
        word_idx_d = word_idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        pack_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    word_idx_d = 8'd0;
                    hold_d     = 1'b1;
                    pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end else if (state_q == DONE) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end else if (state_q == ERR) begin
                    error_d = 1'b1;
                    hold_d  = 1'b0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    if ((n_full == 16'd0) || (n_full > 16'(DEPTH))) begin
                        state_d = ERR;
                    end else begin
                        // N is 1..DEPTH, so N-1 fits the 8-bit word index
                        last_d  = n_full[7:0] - 8'd1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q + in_data;
                end
`endif
                if (word_valid) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = word;
                    wr_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                    word_idx_d = word_idx_q + 8'd1;
                    if (word_idx_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_lo_q   <= 8'd0;
            last_q     <= 8'd0;
            word_idx_q <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            last_q     <= last_d;
            word_idx_q <= word_idx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
